// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_write_arbiter_if                                        |
// | Description : Requester/FIFO write-port bundle around fifo_write_arbiter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic                        full;
  logic [N_REQ-1:0]            ack;
  logic [N_REQ-1:0]            gnt;
  logic                        w_en;
  logic [DATA_WIDTH-1:0]       wdata;

  // master: requesters plus the FIFO's full flag; slave: the arbiter itself
  modport master (
    output req, req_data, full,
    input  ack, gnt, w_en, wdata
  );

  modport slave (
    input  req, req_data, full,
    output ack, gnt, w_en, wdata
  );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_write_arbiter                                           |
// | Description : Round-robin, burst-bounded arbiter for the FIFO write port.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input wire                  wclock,
  input wire                  wreset,
  fifo_write_arbiter_if.slave bus
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_IDX_W-1:0]   r_last_owner;
  logic [N_REQ-1:0]     r_gnt;
  logic [c_CNT_W-1:0]   r_burst_cnt;

  logic [c_IDX_W-1:0]   w_pick;
  logic [c_IDX_W-1:0]   w_scan_idx;
  logic                 w_found;
  logic                 w_grant;
  logic                 w_req_own;
  logic                 w_wen;
  logic                 w_last_write;
  logic                 w_release;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Scan starts just after the previous owner so every requester gets a turn.
  always_comb begin
    w_pick     = '0;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_scan_idx = c_IDX_W'((int'(r_last_owner) + i) % N_REQ);
      if (!w_found && bus.req[w_scan_idx]) begin
        w_pick  = w_scan_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_grant      = (r_state == ST_GRANT);
  assign w_req_own    = bus.req[r_owner];
  // full gates the write in the same cycle so ack always means accepted
  assign w_wen        = w_grant & w_req_own & ~bus.full;
  assign w_last_write = (r_burst_cnt == c_CNT_W'(MAX_BURST - 1));
  assign w_release    = w_grant & (~w_req_own | (w_wen & w_last_write));

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant && (r_owner == c_IDX_W'(i))) begin
        w_wdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.w_en  = w_wen;
  assign bus.ack   = r_gnt & {N_REQ{w_wen}};
  assign bus.gnt   = r_gnt;
  assign bus.wdata = w_wdata;

  always_ff @(posedge wclock or negedge wreset) begin
    if (!wreset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_gnt        <= '0;
      r_last_owner <= c_IDX_W'(N_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state     <= ST_GRANT;
            r_owner     <= w_pick;
            r_gnt       <= N_REQ'(1) << w_pick;
            r_burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_last_owner <= r_owner;
            r_burst_cnt  <= '0;
          end else if (w_wen) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_write_arbiter                                        |
// | Description : Randomised self-checking bench with a behavioural model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic wclock = 1'b0;
  logic wreset = 1'b0;
  always #5 wclock = ~wclock;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclock (wclock),
    .wreset (wreset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // requester side: words still to send and the word currently offered
  int            rem [N];
  logic [DW-1:0] cur [N];

  // behavioural model: who owns the port, writes so far in this grant
  bit m_busy;
  int m_owner, m_cnt, m_last;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            grant_log[$];
  int            acks_log[$];
  logic [N-1:0]  prev_gnt;
  int            wen_count;

  function automatic bit any_rem();
    for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_cnt    = 0;
    m_last   = N - 1;
    prev_gnt = '0;
  endtask

  task automatic drive(input logic f);
    for (int i = 0; i < N; i++) begin
      bus.req[i]                 = (rem[i] > 0);
      bus.req_data[i*DW +: DW]   = cur[i];
    end
    bus.full = f;
  endtask

  // One clock: drive, predict, compare, then advance model and requesters.
  task automatic cycle(input logic f);
    logic [N-1:0]  one;
    logic [N-1:0]  e_gnt, e_ack, a_snap, r_snap;
    logic          e_wen;
    logic [DW-1:0] e_wdata;
    bit            picked;
    int            c;
    drive(f);
    one     = 1;
    e_gnt   = m_busy ? (one << m_owner) : '0;
    e_wen   = m_busy && (rem[m_owner] > 0) && !f;
    e_ack   = e_wen ? e_gnt : '0;
    e_wdata = m_busy ? cur[m_owner] : '0;
    #1;
    n_cmp++;
    if (bus.gnt !== e_gnt) begin
      n_err++; $display("FAIL gnt: got %b expected %b at %0t", bus.gnt, e_gnt, $time);
    end
    n_cmp++;
    if (bus.ack !== e_ack) begin
      n_err++; $display("FAIL ack: got %b expected %b at %0t", bus.ack, e_ack, $time);
    end
    n_cmp++;
    if (bus.w_en !== e_wen) begin
      n_err++; $display("FAIL w_en: got %b expected %b at %0t", bus.w_en, e_wen, $time);
    end
    n_cmp++;
    if (bus.wdata !== e_wdata) begin
      n_err++; $display("FAIL wdata: got %h expected %h at %0t", bus.wdata, e_wdata, $time);
    end
    if (bus.w_en === 1'b1) begin
      fifo_q.push_back(bus.wdata);
      wen_count++;
    end
    if (e_wen) exp_q.push_back(e_wdata);
    if (bus.gnt !== '0 && bus.gnt !== prev_gnt) begin
      for (int i = 0; i < N; i++) if (bus.gnt[i] === 1'b1) grant_log.push_back(i);
      acks_log.push_back(0);
    end
    if (bus.ack !== '0 && acks_log.size() > 0) acks_log[acks_log.size()-1]++;
    prev_gnt = bus.gnt;
    a_snap   = bus.ack;
    r_snap   = bus.req;
    @(posedge wclock);
    if (!m_busy) begin
      picked = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!picked && r_snap[c]) begin
          picked  = 1'b1;
          m_busy  = 1'b1;
          m_owner = c;
          m_cnt   = 0;
        end
      end
    end else if (!r_snap[m_owner] || (e_wen && (m_cnt + 1 == MB))) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (e_wen) begin
      m_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      if (a_snap[i] === 1'b1) begin
        rem[i]--;
        cur[i] = DW'($urandom);
      end
    end
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((any_rem() || m_busy) && k < 400) begin
      cycle(1'b0);
      k++;
    end
    n_cmp++;
    if (any_rem() || m_busy) begin
      n_err++; $display("FAIL drain_%s: got pending work after %0d cycles, required none", name, k);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 8;
      cur[i] = DW'($urandom);
    end
    wreset = 1'b0;
    drive(1'b0);
    repeat (2) @(posedge wclock);
    #1;
    n_cmp++;
    if (bus.gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b required 0", bus.gnt); end
    n_cmp++;
    if (bus.w_en !== 1'b0) begin n_err++; $display("FAIL reset_w_en: got %b required 0", bus.w_en); end
    n_cmp++;
    if (bus.ack !== '0) begin n_err++; $display("FAIL reset_ack: got %b required 0", bus.ack); end
    n_cmp++;
    if (bus.wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h required 0", bus.wdata); end
    wreset = 1'b1;
    model_reset();
    cycle(1'b0);
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_err++; $display("FAIL first_gnt: got %b required 0001", bus.gnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    grant_log.delete();
    acks_log.delete();
    drain("round_robin");
    n_cmp++;
    if (grant_log.size() != 8) begin
      n_err++; $display("FAIL rr_grants: got %0d grants required 8", grant_log.size());
    end
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      n_cmp++;
      if (grant_log[i] != exp_order[i]) begin
        n_err++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, grant_log[i], exp_order[i]);
      end
      n_cmp++;
      if (acks_log[i] != MB) begin
        n_err++; $display("FAIL rr_acks[%0d]: got %0d required %0d", i, acks_log[i], MB);
      end
    end
  endtask

  task automatic test_single();
    grant_log.delete();
    acks_log.delete();
    rem[2]    = 12;
    wen_count = 0;
    repeat (15) cycle(1'b0);
    n_cmp++;
    if (wen_count != 12) begin
      n_err++; $display("FAIL single_writes: got %0d in 15 cycles required 12", wen_count);
    end
    n_cmp++;
    if (rem[2] != 0) begin
      n_err++; $display("FAIL single_remaining: got %0d required 0", rem[2]);
    end
    n_cmp++;
    if (grant_log.size() != 3) begin
      n_err++; $display("FAIL single_grants: got %0d required 3", grant_log.size());
    end
    for (int i = 0; i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[i] != 2 || acks_log[i] != MB) begin
        n_err++; $display("FAIL single_grant[%0d]: got owner %0d acks %0d required owner 2 acks %0d",
                          i, grant_log[i], acks_log[i], MB);
      end
    end
    drain("single");
  endtask

  task automatic test_full_stall();
    int k;
    rem[1] = 6;
    repeat (3) cycle(1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1);
      n_cmp++;
      if (bus.gnt !== 4'b0010) begin
        n_err++; $display("FAIL stall_gnt[%0d]: got %b required 0010", s, bus.gnt);
      end
    end
    wen_count = 0;
    k = 0;
    while (bus.gnt !== '0 && k < 20) begin
      cycle(1'b0);
      k++;
    end
    n_cmp++;
    if (wen_count != 2) begin
      n_err++; $display("FAIL stall_tail_writes: got %0d required 2", wen_count);
    end
    drain("full_stall");
  endtask

  task automatic test_early_drop();
    int exp_own [3] = '{3, 0, 2};
    int exp_ack [3] = '{1, 2, 2};
    grant_log.delete();
    acks_log.delete();
    rem[3] = 1;
    cycle(1'b0);
    rem[0] = 2;
    rem[2] = 2;
    drain("early_drop");
    n_cmp++;
    if (grant_log.size() != 3) begin
      n_err++; $display("FAIL drop_grants: got %0d required 3", grant_log.size());
    end
    for (int i = 0; i < grant_log.size() && i < 3; i++) begin
      n_cmp++;
      if (grant_log[i] != exp_own[i] || acks_log[i] != exp_ack[i]) begin
        n_err++; $display("FAIL drop_grant[%0d]: got owner %0d acks %0d required owner %0d acks %0d",
                          i, grant_log[i], acks_log[i], exp_own[i], exp_ack[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    for (int i = 0; i < N; i++) rem[i] = 6;
    k = 0;
    while (!(m_busy && m_cnt == 2) && k < 50) begin
      cycle(1'b0);
      k++;
    end
    n_cmp++;
    if (!(m_busy && m_cnt == 2)) begin
      n_err++; $display("FAIL areset_setup: got no mid-burst point, required one");
    end
    #2;
    wreset = 1'b0;
    #1;
    n_cmp++;
    if (bus.gnt !== '0) begin n_err++; $display("FAIL areset_gnt: got %b required 0", bus.gnt); end
    n_cmp++;
    if (bus.w_en !== 1'b0) begin n_err++; $display("FAIL areset_w_en: got %b required 0", bus.w_en); end
    n_cmp++;
    if (bus.ack !== '0) begin n_err++; $display("FAIL areset_ack: got %b required 0", bus.ack); end
    @(posedge wclock);
    #1;
    wreset = 1'b1;
    model_reset();
    drain("async_reset");
  endtask

  task automatic test_random();
    logic f;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 9);
      end
      f = ($urandom_range(0, 3) == 0);
      cycle(f);
    end
    drain("random");
  endtask

  task automatic test_scoreboard();
    n_cmp++;
    if (fifo_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fifo_count: got %0d words required %0d", fifo_q.size(), exp_q.size());
    end
    for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (fifo_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fifo_word[%0d]: got %h required %h", i, fifo_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cur[i] = '0;
    end
    model_reset();
    wen_count = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_full_stall();
    test_early_drop();
    test_async_reset();
    test_random();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
